csat_assign_sweeper: RTL and testbench
======================================

CSAT_ASSIGN_SWEEPER -- requirements
Module: csat_assign_sweeper

Interface
REQ-001 SHALL have parameter NUM_VARS, default 13, giving the candidate assignment width (a[7:0] = bits 7:0, b[4:0] = bits 12:8 for the 8x5 multiplier benchmarks).
REQ-002 SHALL have parameter SAT_LATENCY, default 1, giving the cycles from assign_o change to the matching sat_i sample (range 1..8).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse; begins a sweep when IDLE or DONE, ignored otherwise.
REQ-006 abort  input  1  stops an active sweep.
REQ-007 sat_i  input  1  benchmark circuit output for the candidate issued SAT_LATENCY cycles earlier.
REQ-008 assign_o  output  NUM_VARS  candidate driven onto the benchmark inputs.
REQ-009 busy  output  1  high in SWEEP or DRAIN.
REQ-010 done  output  1  one-cycle pulse on entry to DONE.
REQ-011 found  output  1  sticky result flag, valid while in DONE.
REQ-012 solution  output  NUM_VARS  first satisfying assignment, valid when found=1.
REQ-013 tested_count  output  NUM_VARS+1  number of candidates whose sat_i was evaluated.

Function
REQ-014 The FSM SHALL have states IDLE, SWEEP, DRAIN and DONE.
REQ-015 IDLE/DONE + start SHALL clear found, solution and tested_count, load candidate counter with 0 and enter SWEEP.
REQ-016 In SWEEP, assign_o SHALL equal the counter, and the counter SHALL increment by 1 each cycle.
REQ-017 A SAT_LATENCY-deep valid/candidate shift pipeline SHALL tag each issued candidate; sat_i SHALL only be honoured when the tap valid bit is 1.
REQ-018 Each honoured tap SHALL increment tested_count, saturating at 2^NUM_VARS.
REQ-019 Honoured sat_i=1 SHALL capture the tap candidate into solution, set found, flush the pipeline valid bits and enter DONE the next cycle; later in-flight candidates SHALL be discarded.
REQ-020 Issuing candidate 2^NUM_VARS-1 SHALL enter DRAIN without counter wrap-around; DRAIN SHALL exit to DONE once the pipeline is empty, with found=0 unless a drained candidate hit.
REQ-021 abort in SWEEP/DRAIN SHALL flush the pipeline and enter DONE with found=0; if a hit and abort coincide, the hit SHALL win.
REQ-022 start while busy SHALL be ignored; start and abort together in IDLE/DONE SHALL start a sweep.
REQ-023 assign_o SHALL hold its last value outside SWEEP.

Reset
REQ-024 rst_n low SHALL force IDLE, assign_o=0, busy=0, done=0, found=0, solution=0, tested_count=0 and all pipeline valid bits 0, including mid-sweep.

Configuration
REQ-025 CSAT_SWEEP_SKIP_TRIVIAL_EN defined: the counter SHALL skip any candidate whose a field (bits 7:0) is 0 or 1 or whose b field (bits 12:8) is 0 or 1, and such candidates SHALL never reach assign_o. The same rule holds for the default NUM_VARS width; other widths SHALL split NUM_VARS-5 / 5.
REQ-026 Macro undefined: every candidate 0..2^NUM_VARS-1 SHALL be issued.

Structure
REQ-027 A shared package csat_pkg SHALL hold the FSM state enum and the SAT_LATENCY maximum constant.
REQ-028 The latency pipeline SHALL be a sub-module csat_tag_pipe (valid + data shift register with synchronous flush).

Verification
REQ-029 Model sat_i = (candidate==13'h0A5), SAT_LATENCY=1, start -> done after 167 cycles, found=1, solution=13'h0A5, tested_count=166.
REQ-030 Same model, SAT_LATENCY=4 -> solution=13'h0A5, and candidates 0x0A6..0x0A8 are discarded without being counted.
REQ-031 sat_i tied 0, NUM_VARS=4 -> DRAIN entered after candidate 15, done with found=0, tested_count=16, no wrap to 0.
REQ-032 abort pulsed at cycle 10 of a sweep -> DONE next cycle with found=0, and assign_o holds its value.
REQ-033 rst_n dropped mid-sweep for 1 cycle -> all outputs 0, IDLE; start then restarts from candidate 0.
REQ-034 With CSAT_SWEEP_SKIP_TRIVIAL_EN defined -> the first issued candidate is 13'h0202, and no issued candidate has an a or b field of 0 or 1.

Source files
------------

// File: rtl/csat_pkg.sv
// Shared types and limits for the circuit-SAT exhaustive assignment sweeper.
package csat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN,
        ST_DONE
    } csat_state_e;

    localparam int SAT_LATENCY_MAX = 8;
    // Width of the b operand field (top bits); a takes the rest.
    localparam int B_FIELD_W = 5;

endpackage

// File: rtl/csat_tag_pipe.sv
// Valid/candidate tag pipeline aligning each issued candidate with its sat_i sample.
// Stage 0 is the live input; LAT-1 registered stages follow, tap is the last one.
module csat_tag_pipe #(
    parameter int W   = 13,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         tap_vld,
    output logic [W-1:0] tap_dat,
    output logic         occupied
);
    localparam int STAGES = LAT - 1;

    generate
        if (STAGES == 0) begin : g_comb
            assign tap_vld  = in_vld;
            assign tap_dat  = in_dat;
            assign occupied = in_vld;
        end else begin : g_reg
            logic [STAGES:1]         vld_pipe;
            logic [STAGES:1][W-1:0]  dat_pipe;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_pipe <= '0;
                    dat_pipe <= '0;
                end else begin
                    for (int i = STAGES; i >= 2; i--) begin
                        vld_pipe[i] <= flush ? 1'b0 : vld_pipe[i-1];
                        dat_pipe[i] <= dat_pipe[i-1];
                    end
                    vld_pipe[1] <= flush ? 1'b0 : in_vld;
                    dat_pipe[1] <= in_dat;
                end
            end

            assign tap_vld  = vld_pipe[STAGES];
            assign tap_dat  = dat_pipe[STAGES];
            assign occupied = in_vld | (|vld_pipe);
        end
    endgenerate

endmodule

// File: rtl/csat_assign_sweeper.sv
// Exhaustive candidate sweeper for circuit-SAT benchmarks: issues assignments,
// tracks results through a latency pipe, stops at the first hit.
// Optional: CSAT_SWEEP_SKIP_TRIVIAL_EN skips candidates with an a or b field of 0 or 1.
module csat_assign_sweeper
    import csat_pkg::*;
#(
    parameter int NUM_VARS    = 13,
    parameter int SAT_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                sat_i,
    output logic [NUM_VARS-1:0] assign_o,
    output logic                busy,
    output logic                done,
    output logic                found,
    output logic [NUM_VARS-1:0] solution,
    output logic [NUM_VARS:0]   tested_count
);
    localparam int LAT = (SAT_LATENCY < 1) ? 1 :
                         ((SAT_LATENCY > SAT_LATENCY_MAX) ? SAT_LATENCY_MAX : SAT_LATENCY);

    localparam logic [NUM_VARS-1:0] CAND_MAX  = {NUM_VARS{1'b1}};
    localparam logic [NUM_VARS-1:0] CAND_ONE  = 1;
    localparam logic [NUM_VARS:0]   TEST_MAX  = {1'b1, {NUM_VARS{1'b0}}};
    localparam logic [NUM_VARS:0]   TEST_ONE  = 1;

`ifdef CSAT_SWEEP_SKIP_TRIVIAL_EN
    localparam int A_W = NUM_VARS - B_FIELD_W;
    localparam logic [A_W-1:0]      A_MIN      = 2;
    localparam logic [NUM_VARS-1:0] CAND_FIRST = (NUM_VARS'(2) << A_W) | NUM_VARS'(2);

    // b only ever increments from 2, so only a carry out of a needs fixing.
    function automatic logic [NUM_VARS-1:0] next_cand(input logic [NUM_VARS-1:0] c);
        logic [NUM_VARS-1:0] n;
        n = c + CAND_ONE;
        if (n[A_W-1:0] < A_MIN) n[A_W-1:0] = A_MIN;
        return n;
    endfunction
`else
    localparam logic [NUM_VARS-1:0] CAND_FIRST = '0;

    function automatic logic [NUM_VARS-1:0] next_cand(input logic [NUM_VARS-1:0] c);
        return c + CAND_ONE;
    endfunction
`endif

    csat_state_e         state;
    logic                tap_vld;
    logic [NUM_VARS-1:0] tap_dat;
    logic                occupied;
    logic                active;
    logic                hit;
    logic                flush;

    assign active = (state == ST_SWEEP) || (state == ST_DRAIN);
    assign hit    = active && tap_vld && sat_i;
    assign flush  = active && (hit || abort);

    csat_tag_pipe #(
        .W   (NUM_VARS),
        .LAT (LAT)
    ) u_tag_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_vld   (state == ST_SWEEP),
        .in_dat   (assign_o),
        .tap_vld  (tap_vld),
        .tap_dat  (tap_dat),
        .occupied (occupied)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            assign_o     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            found        <= 1'b0;
            solution     <= '0;
            tested_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state        <= ST_SWEEP;
                        assign_o     <= CAND_FIRST;
                        busy         <= 1'b1;
                        found        <= 1'b0;
                        solution     <= '0;
                        tested_count <= '0;
                    end
                end
                ST_SWEEP, ST_DRAIN: begin
                    if (tap_vld && (tested_count != TEST_MAX))
                        tested_count <= tested_count + TEST_ONE;
                    // A hit outranks a coincident abort.
                    if (hit) begin
                        solution <= tap_dat;
                        found    <= 1'b1;
                        state    <= ST_DONE;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                    end else if (abort) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (state == ST_SWEEP) begin
                        if (assign_o == CAND_MAX)
                            state <= ST_DRAIN;
                        else
                            assign_o <= next_cand(assign_o);
                    end else if (!occupied) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csat_assign_sweeper.sv
// Directed bench: three sweeper instances (13b/lat1, 13b/lat4, small/lat1) run side by side.
module tb_csat_assign_sweeper;
    import csat_pkg::*;

`ifdef CSAT_SWEEP_SKIP_TRIVIAL_EN
    localparam int SN = 7;
`else
    localparam int SN = 4;
`endif

    logic clk = 1'b0;
    logic rst_n, start, abort;
    always #5 clk = ~clk;

    logic [12:0] a_assign, a_sol, b_assign, b_sol;
    logic [13:0] a_tested, b_tested;
    logic        a_busy, a_done, a_found, b_busy, b_done, b_found;
    logic [SN-1:0] c_assign, c_sol;
    logic [SN:0]   c_tested;
    logic        c_busy, c_done, c_found;
    logic        sat_a, sat_b;
    logic [12:0] h1, h2, h3;

    // Benchmark models: satisfied only by 0x0A5; lat4 instance sees a 3-register delay.
    assign sat_a = (a_assign == 13'h0A5);
    always @(posedge clk) begin
        h1 <= b_assign;
        h2 <= h1;
        h3 <= h2;
    end
    assign sat_b = (h3 == 13'h0A5);

    csat_assign_sweeper #(.NUM_VARS(13), .SAT_LATENCY(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sat_i(sat_a),
        .assign_o(a_assign), .busy(a_busy), .done(a_done), .found(a_found),
        .solution(a_sol), .tested_count(a_tested));

    csat_assign_sweeper #(.NUM_VARS(13), .SAT_LATENCY(4)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sat_i(sat_b),
        .assign_o(b_assign), .busy(b_busy), .done(b_done), .found(b_found),
        .solution(b_sol), .tested_count(b_tested));

    csat_assign_sweeper #(.NUM_VARS(SN), .SAT_LATENCY(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sat_i(1'b0),
        .assign_o(c_assign), .busy(c_busy), .done(c_done), .found(c_found),
        .solution(c_sol), .tested_count(c_tested));

    int vecs = 0;
    int miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d_a, d_b, d_c;
        logic [31:0] a_snap [4];
        logic [31:0] b_snap [4];
        logic [31:0] c_snap [3];
        logic [31:0] drain_snap [3];
        logic [31:0] held;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        d_a = 0; d_b = 0; d_c = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_assign", a_assign, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_found", a_found, 0);
        chk("rst_solution", a_sol, 0);
        chk("rst_tested", a_tested, 0);

`ifdef CSAT_SWEEP_SKIP_TRIVIAL_EN
        begin
            logic [12:0] exp_c;
            int bad;
            bad = 0;
            start = 1'b1; tick(); start = 1'b0;
            chk("skip_first", a_assign, 32'h0202);
            exp_c = 13'h0202;
            for (int i = 0; i < 600; i++) begin
                tick();
                exp_c = exp_c + 13'd1;
                while (exp_c[7:0] < 8'd2 || exp_c[12:8] < 5'd2) exp_c = exp_c + 13'd1;
                if (a_assign !== exp_c || a_assign[7:0] < 8'd2 || a_assign[12:8] < 5'd2) bad++;
            end
            chk("skip_sequence_bad", bad, 0);
            chk("skip_still_busy", a_busy, 1);
        end
`else
        // Main sweep: cycle n = 1 is the edge that samples start.
        start = 1'b1; tick(); start = 1'b0;
        chk("first_candidate", a_assign, 0);
        chk("busy_after_start", a_busy, 1);
        for (int i = 2; i <= 175; i++) begin
            start = (i == 50);
            tick();
            start = 1'b0;
            if (i == 50) chk("start_while_busy_ignored", a_assign, 49);
            if (i == 17) begin
                drain_snap[0] = c_busy; drain_snap[1] = c_assign; drain_snap[2] = c_done;
            end
            if (i == 30) chk("small_no_wrap", c_assign, 15);
            if (i == 168) chk("done_one_pulse", a_done, 0);
            if (a_done && d_a == 0) begin
                d_a = i;
                a_snap[0] = a_found; a_snap[1] = a_sol; a_snap[2] = a_tested; a_snap[3] = a_assign;
            end
            if (b_done && d_b == 0) begin
                d_b = i;
                b_snap[0] = b_found; b_snap[1] = b_sol; b_snap[2] = b_tested; b_snap[3] = b_assign;
            end
            if (c_done && d_c == 0) begin
                d_c = i;
                c_snap[0] = c_found; c_snap[1] = c_tested; c_snap[2] = c_assign;
            end
        end
        chk("lat1_done_cycle", d_a, 167);
        chk("lat1_found", a_snap[0], 1);
        chk("lat1_solution", a_snap[1], 32'h0A5);
        chk("lat1_tested", a_snap[2], 166);
        chk("lat1_assign_hold", a_snap[3], 32'h0A5);
        chk("lat4_done_cycle", d_b, 170);
        chk("lat4_found", b_snap[0], 1);
        chk("lat4_solution", b_snap[1], 32'h0A5);
        chk("lat4_tested", b_snap[2], 166);
        chk("lat4_assign_hold", b_snap[3], 32'h0A8);
        chk("drain_busy", drain_snap[0], 1);
        chk("drain_assign", drain_snap[1], 15);
        chk("drain_done", drain_snap[2], 0);
        chk("small_done_cycle", d_c, 18);
        chk("small_found", c_snap[0], 0);
        chk("small_tested", c_snap[1], 16);
        chk("small_assign", c_snap[2], 15);

        // start+abort together in DONE starts; then abort at cycle 10.
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", a_busy, 1);
        chk("start_abort_assign", a_assign, 0);
        for (int i = 2; i <= 9; i++) tick();
        held = a_assign;
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_done", a_done, 1);
        chk("abort_found", a_found, 0);
        chk("abort_busy", a_busy, 0);
        chk("abort_assign", a_assign, 8);
        chk("abort_assign_vs_before", a_assign, held);
        repeat (3) tick();
        chk("abort_assign_hold", a_assign, 8);
        chk("abort_done_dropped", a_done, 0);

        // Reset mid-sweep, then restart from candidate 0.
        start = 1'b1; tick(); start = 1'b0;
        repeat (19) tick();
        chk("pre_reset_busy", a_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_assign", a_assign, 0);
        chk("async_rst_busy", a_busy, 0);
        chk("async_rst_tested", a_tested, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_assign", a_assign, 0);
        chk("post_rst_busy", a_busy, 0);
        chk("post_rst_lat4_tested", b_tested, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("restart_assign", a_assign, 0);
        chk("restart_busy", a_busy, 1);
        repeat (5) tick();
        chk("restart_count", a_assign, 5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
